// File: rtl/msrv_32_imem_responder.sv
// msrv_32_imem_responder: instruction-memory responder for the msrv_32 fetch port.
// Storage is a DEPTH_WORDS x 32 array written through a separate load/debug port.
// Each fetch returns a registered data beat exactly WAIT_STATES+1 cycles after it is accepted.
// Handshake: a request is accepted on any rising edge where req_valid_in and ahb_ready_out
// are both high. ahb_ready_out high in DATA (or ERR2) marks the cycle in which instr_out
// (or err_out) carries the beat. That same cycle can accept the next request.
// Optional feature macro: MSRV32_IMEM_ERR_CHECK_EN. When it is defined, the block flags
// misaligned and out-of-range fetches with a two-cycle error response (ERR1, ERR2).
module msrv_32_imem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  input  logic [31:0] imaddr_in,
  input  logic        prog_we_in,
  input  logic [31:0] prog_addr_in,
  input  logic [31:0] prog_data_in,
  output logic [31:0] instr_out,
  output logic        ahb_ready_out,
  output logic        err_out
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef MSRV32_IMEM_ERR_CHECK_EN
    , S_ERR1,
    S_ERR2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     instr_q;
  logic            rd_en;
  logic [AW-1:0]   rd_idx;
  logic            ready;
  logic            err;
  logic [AW-1:0]   fetch_idx;
  logic [31:0]     mem [DEPTH_WORDS];

  assign fetch_idx = imaddr_in[AW+1:2];

`ifdef MSRV32_IMEM_ERR_CHECK_EN
  logic addr_bad;
  // Misaligned, or a word index beyond the end of storage.
  assign addr_bad = (imaddr_in[1:0] != 2'b00) ||
                    ({2'b00, imaddr_in[31:2]} >= 32'(DEPTH_WORDS));
`endif

  // Address bits outside the storage index are deliberately ignored (wrap-around).
  logic unused_bits;
  assign unused_bits = ^{imaddr_in[31:AW+2], imaddr_in[1:0],
                         prog_addr_in[31:AW+2], prog_addr_in[1:0]};

  // Next-state, wait counter, read strobe and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    rd_idx  = addr_q;
    ready   = 1'b1;
    err     = 1'b0;

    case (state_q)
      S_WAIT: begin
        ready = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          rd_en   = 1'b1;
          rd_idx  = addr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef MSRV32_IMEM_ERR_CHECK_EN
      S_ERR1: begin
        ready   = 1'b0;
        err     = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
`endif
      S_DATA:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance overrides the default fall-back to IDLE (back-to-back fetches).
    if (ready && req_valid_in) begin
`ifdef MSRV32_IMEM_ERR_CHECK_EN
      if (addr_bad) begin
        state_d = S_ERR1;
      end else
`endif
      if (WAIT_STATES == 0) begin
        state_d = S_DATA;
        rd_en   = 1'b1;
        rd_idx  = fetch_idx;
      end else begin
        state_d = S_WAIT;
        cnt_d   = WAIT_LOAD;
        addr_d  = fetch_idx;
      end
    end
  end

  // FSM state, wait counter and latched fetch index.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Registered instruction: loaded on entry to DATA, otherwise held.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      instr_q <= NOP_INSTR;
    end else if (rd_en) begin
      instr_q <= mem[rd_idx];
    end
  end

  // Load-port write; the contents are not reset, and a read in the same cycle sees the old word.
  always_ff @(posedge clk_in) begin
    if (prog_we_in) begin
      mem[prog_addr_in[AW+1:2]] <= prog_data_in;
    end
  end

  assign instr_out     = instr_q;
  assign ahb_ready_out = ready;
  assign err_out       = err;

endmodule
